// File: rtl/calc_entry_fsm.sv
`timescale 1ns/1ps
// Decimal operand/operator entry from keypad codes; block write of OP1/OP2/OPR/RESULT to RAM on ENTER.
// Latency: key effects visible one cycle after the char_valid strobe; each RAM word takes >=1 cycle.
// Backpressure: a word is held on mem_addr/mem_wdata until mem_ready; keys arriving while busy are dropped.
module calc_entry_fsm #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 9,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic              iCLK_50,
    input  logic              iRST_n,
    input  logic [3:0]        char_code,
    input  logic              char_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [3:0]        opr,
    output logic [3:0]        digit_cnt,
    output logic              busy,
    output logic              ovf_err,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_OP1, S_OP2, S_WR_OP1, S_WR_OP2, S_WR_OPR, S_WR_RES
    } state_t;

    localparam logic [DATA_W-1:0] TEN = DATA_W'(10);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [3:0]        opr_q, cnt_q, op1_cnt_q;
    logic              ovf_q, done_q;

    logic              in_wr, key_vld;
    logic              is_digit, is_op, is_ent, is_bs;
    logic [DATA_W-1:0] op_cur;
    logic [DATA_W+3:0] op_ext, mac;
    logic              digit_ok;

    assign in_wr    = state inside {S_WR_OP1, S_WR_OP2, S_WR_OPR, S_WR_RES};
    assign key_vld  = char_valid && !in_wr;
    assign is_digit = (char_code <= 4'd9);
    assign is_op    = (char_code >= 4'hA) && (char_code <= 4'hD);
    assign is_ent   = (char_code == 4'hE);
    assign is_bs    = (char_code == 4'hF);

    // op*10+d in DATA_W+4 bits: any carry into the top nibble means the operand would not fit
    assign op_cur   = (state == S_OP2) ? op2_q : op1_q;
    assign op_ext   = {4'b0000, op_cur};
    assign mac      = (op_ext << 3) + (op_ext << 1) + {{DATA_W{1'b0}}, char_code};
    assign digit_ok = (cnt_q < 4'(MAX_DIGITS)) && (mac[DATA_W+3:DATA_W] == 4'b0000);

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (key_vld && is_digit) state_nxt = S_OP1;
            S_OP1: begin
                if (key_vld && is_op)                       state_nxt = S_OP2;
                else if (key_vld && is_bs && cnt_q <= 4'd1) state_nxt = S_IDLE;
            end
            S_OP2: begin
                if (key_vld && is_bs && cnt_q == 4'd0)       state_nxt = S_OP1;
                else if (key_vld && is_ent && cnt_q != 4'd0) state_nxt = S_WR_OP1;
            end
            S_WR_OP1: if (mem_ready) state_nxt = S_WR_OP2;
            S_WR_OP2: if (mem_ready) state_nxt = S_WR_OPR;
            S_WR_OPR: if (mem_ready) state_nxt = S_WR_RES;
            S_WR_RES: if (mem_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            op1_q     <= '0;
            op2_q     <= '0;
            opr_q     <= '0;
            cnt_q     <= '0;
            op1_cnt_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == S_WR_RES) && mem_ready;
            if (key_vld) begin
                case (state)
                    S_IDLE: if (is_digit) begin
                        op1_q <= DATA_W'(char_code);
                        op2_q <= '0;
                        opr_q <= '0;
                        cnt_q <= 4'd1;
                        ovf_q <= 1'b0;
                    end
                    S_OP1: begin
                        if (is_digit) begin
                            if (digit_ok) begin
                                op1_q <= mac[DATA_W-1:0];
                                cnt_q <= cnt_q + 4'd1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (is_op) begin
                            opr_q     <= char_code;
                            op1_cnt_q <= cnt_q;
                            cnt_q     <= 4'd0;
                        end else if (is_bs) begin
                            if (cnt_q > 4'd1) begin
                                op1_q <= op1_q / TEN;
                                cnt_q <= cnt_q - 4'd1;
                            end else begin
                                op1_q <= '0;
                                cnt_q <= 4'd0;
                            end
                        end
                    end
                    S_OP2: begin
                        if (is_digit) begin
                            if (digit_ok) begin
                                op2_q <= mac[DATA_W-1:0];
                                cnt_q <= cnt_q + 4'd1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (is_op && cnt_q == 4'd0) begin
                            opr_q <= char_code;
                        end else if (is_bs) begin
                            if (cnt_q != 4'd0) begin
                                op2_q <= op2_q / TEN;
                                cnt_q <= cnt_q - 4'd1;
                            end else begin
                                // back out of the operator: resume editing op1 where it was left
                                opr_q <= '0;
                                cnt_q <= op1_cnt_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        case (state)
            S_WR_OP1: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                mem_addr  = ADDR_W'(BASE_ADDR);
                mem_wdata = op1_q;
            end
            S_WR_OP2: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                mem_addr  = ADDR_W'(BASE_ADDR + 1);
                mem_wdata = op2_q;
            end
            S_WR_OPR: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                mem_addr  = ADDR_W'(BASE_ADDR + 2);
                mem_wdata = DATA_W'(opr_q);
            end
            S_WR_RES: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                mem_addr  = ADDR_W'(BASE_ADDR + 3);
                mem_wdata = '0;
            end
            default: ;
        endcase
    end

    assign op1       = op1_q;
    assign op2       = op2_q;
    assign opr       = opr_q;
    assign digit_cnt = cnt_q;
    assign ovf_err   = ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
`timescale 1ns/1ps
// Directed bench for calc_entry_fsm: default, 8-bit and 3-digit instances share one key stream.
module tb_calc_entry_fsm;

    logic        clk, rst_n;
    logic [3:0]  char_code;
    logic        char_valid, mem_ready;

    logic        we, busy, ovf, done;
    logic [9:0]  addr;
    logic [31:0] wdata, op1, op2;
    logic [3:0]  opr, cnt;

    logic        we8, busy8, ovf8, done8;
    logic [9:0]  addr8;
    logic [7:0]  wdata8, op1_8, op2_8;
    logic [3:0]  opr8, cnt8;

    logic        we3, busy3, ovf3, done3;
    logic [9:0]  addr3;
    logic [31:0] wdata3, op1_3, op2_3;
    logic [3:0]  opr3, cnt3;

    int n_vec  = 0;
    int n_fail = 0;

    calc_entry_fsm dut (
        .iCLK_50(clk), .iRST_n(rst_n), .char_code(char_code), .char_valid(char_valid),
        .mem_we(we), .mem_addr(addr), .mem_wdata(wdata), .mem_ready(mem_ready),
        .op1(op1), .op2(op2), .opr(opr), .digit_cnt(cnt),
        .busy(busy), .ovf_err(ovf), .done(done)
    );

    calc_entry_fsm #(.DATA_W(8)) dut8 (
        .iCLK_50(clk), .iRST_n(rst_n), .char_code(char_code), .char_valid(char_valid),
        .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8), .mem_ready(mem_ready),
        .op1(op1_8), .op2(op2_8), .opr(opr8), .digit_cnt(cnt8),
        .busy(busy8), .ovf_err(ovf8), .done(done8)
    );

    calc_entry_fsm #(.MAX_DIGITS(3)) dut3 (
        .iCLK_50(clk), .iRST_n(rst_n), .char_code(char_code), .char_valid(char_valid),
        .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3), .mem_ready(mem_ready),
        .op1(op1_3), .op2(op2_3), .opr(opr3), .digit_cnt(cnt3),
        .busy(busy3), .ovf_err(ovf3), .done(done3)
    );

    typedef struct {
        logic [3:0]  code;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [3:0]  e_opr;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl [20];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // called on a falling edge; returns on the next falling edge with the key registered
    task automatic press(input logic [3:0] c);
        char_code  = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] words [4];

        tbl[0]  = '{4'h1, 32'd1,   32'd0, 4'h0, 4'd1};
        tbl[1]  = '{4'h2, 32'd12,  32'd0, 4'h0, 4'd2};
        tbl[2]  = '{4'h3, 32'd123, 32'd0, 4'h0, 4'd3};
        tbl[3]  = '{4'hF, 32'd12,  32'd0, 4'h0, 4'd2};
        tbl[4]  = '{4'hF, 32'd1,   32'd0, 4'h0, 4'd1};
        tbl[5]  = '{4'hF, 32'd0,   32'd0, 4'h0, 4'd0};
        tbl[6]  = '{4'hE, 32'd0,   32'd0, 4'h0, 4'd0};
        tbl[7]  = '{4'h5, 32'd5,   32'd0, 4'h0, 4'd1};
        tbl[8]  = '{4'hB, 32'd5,   32'd0, 4'hB, 4'd0};
        tbl[9]  = '{4'hF, 32'd5,   32'd0, 4'h0, 4'd1};
        tbl[10] = '{4'h7, 32'd57,  32'd0, 4'h0, 4'd2};
        tbl[11] = '{4'hE, 32'd57,  32'd0, 4'h0, 4'd2};
        tbl[12] = '{4'hC, 32'd57,  32'd0, 4'hC, 4'd0};
        tbl[13] = '{4'hA, 32'd57,  32'd0, 4'hA, 4'd0};
        tbl[14] = '{4'hE, 32'd57,  32'd0, 4'hA, 4'd0};
        tbl[15] = '{4'h0, 32'd57,  32'd0, 4'hA, 4'd1};
        tbl[16] = '{4'h4, 32'd57,  32'd4, 4'hA, 4'd2};
        tbl[17] = '{4'hD, 32'd57,  32'd4, 4'hA, 4'd2};
        tbl[18] = '{4'hF, 32'd57,  32'd0, 4'hA, 4'd1};
        tbl[19] = '{4'h9, 32'd57,  32'd9, 4'hA, 4'd2};

        words[0] = 32'd12;
        words[1] = 32'd34;
        words[2] = 32'hA;
        words[3] = 32'd0;

        rst_n      = 1'b0;
        char_code  = 4'h0;
        char_valid = 1'b0;
        mem_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst op1", op1, 0);
        chk("rst op2", op2, 0);
        chk("rst opr", {28'd0, opr}, 0);
        chk("rst cnt", {28'd0, cnt}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst ovf", {31'd0, ovf}, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst mem_we", {31'd0, we}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            press(tbl[i].code);
            chk($sformatf("v%0d op1", i), op1, tbl[i].e_op1);
            chk($sformatf("v%0d op2", i), op2, tbl[i].e_op2);
            chk($sformatf("v%0d opr", i), {28'd0, opr}, {28'd0, tbl[i].e_opr});
            chk($sformatf("v%0d cnt", i), {28'd0, cnt}, {28'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d busy", i), {31'd0, busy}, 0);
        end

        // 12 A 34 E with ready already high: four back-to-back words then done
        do_reset();
        mem_ready = 1'b1;
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
        press(4'hE);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr%0d we", k), {31'd0, we}, 1);
            chk($sformatf("wr%0d busy", k), {31'd0, busy}, 1);
            chk($sformatf("wr%0d addr", k), {22'd0, addr}, k);
            chk($sformatf("wr%0d data", k), wdata, words[k]);
            chk($sformatf("wr%0d done", k), {31'd0, done}, 0);
            @(negedge clk);
        end
        chk("wr end we", {31'd0, we}, 0);
        chk("wr end done", {31'd0, done}, 1);
        chk("wr end busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("wr done pulse", {31'd0, done}, 0);
        chk("retain op1", op1, 12);
        chk("retain op2", op2, 34);
        chk("retain opr", {28'd0, opr}, 32'hA);

        // stall on word 1 for five cycles; a key arriving meanwhile must be dropped
        press(4'h8);
        chk("idle digit op1", op1, 8);
        chk("idle digit op2", op2, 0);
        chk("idle digit opr", {28'd0, opr}, 0);
        press(4'hC); press(4'h6); press(4'hE);
        chk("st w0 addr", {22'd0, addr}, 0);
        chk("st w0 data", wdata, 8);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                char_code  = 4'h5;
                char_valid = 1'b1;
            end
            @(negedge clk);
            char_valid = 1'b0;
            chk($sformatf("st%0d we", j), {31'd0, we}, 1);
            chk($sformatf("st%0d addr", j), {22'd0, addr}, 1);
            chk($sformatf("st%0d data", j), wdata, 6);
        end
        chk("st key dropped op2", op2, 6);
        chk("st cnt", {28'd0, cnt}, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("st w2 addr", {22'd0, addr}, 2);
        chk("st w2 data", wdata, 32'hC);
        @(negedge clk);
        chk("st w3 addr", {22'd0, addr}, 3);
        chk("st w3 data", wdata, 0);
        @(negedge clk);
        chk("st done", {31'd0, done}, 1);
        chk("st we off", {31'd0, we}, 0);

        // asynchronous reset while parked on the operator word
        do_reset();
        mem_ready = 1'b1;
        press(4'h1); press(4'hA); press(4'h2); press(4'hE);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("ar pre we", {31'd0, we}, 1);
        chk("ar pre addr", {22'd0, addr}, 2);
        #5;
        rst_n = 1'b0;
        #1;
        chk("ar we", {31'd0, we}, 0);
        chk("ar busy", {31'd0, busy}, 0);
        chk("ar addr", {22'd0, addr}, 0);
        chk("ar op1", op1, 0);
        chk("ar opr", {28'd0, opr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(4'h3);
        chk("ar idle digit op1", op1, 3);
        chk("ar idle digit cnt", {28'd0, cnt}, 1);
        chk("ar idle busy", {31'd0, busy}, 0);

        // DATA_W=8 overflow guard
        do_reset();
        press(4'h2);
        chk("w8 op1 2", {24'd0, op1_8}, 2);
        press(4'h5);
        chk("w8 op1 25", {24'd0, op1_8}, 25);
        press(4'h5);
        chk("w8 op1 255", {24'd0, op1_8}, 255);
        chk("w8 ovf clear", {31'd0, ovf8}, 0);
        press(4'h6);
        chk("w8 op1 hold", {24'd0, op1_8}, 255);
        chk("w8 ovf set", {31'd0, ovf8}, 1);
        chk("w8 cnt", {28'd0, cnt8}, 3);
        chk("w32 op1 2556", op1, 2556);

        // MAX_DIGITS=3 digit-count guard, sticky until next IDLE digit
        do_reset();
        press(4'h1); press(4'h2); press(4'h3);
        chk("m3 op1 123", op1_3, 123);
        chk("m3 ovf clear", {31'd0, ovf3}, 0);
        press(4'h4);
        chk("m3 op1 hold", op1_3, 123);
        chk("m3 ovf set", {31'd0, ovf3}, 1);
        chk("m3 cnt", {28'd0, cnt3}, 3);
        chk("m9 op1 1234", op1, 1234);
        chk("m9 ovf", {31'd0, ovf}, 0);
        press(4'hF); press(4'hF);
        chk("m3 op1 1", op1_3, 1);
        chk("m3 ovf sticky", {31'd0, ovf3}, 1);
        press(4'hF);
        chk("m3 op1 0", op1_3, 0);
        press(4'h7);
        chk("m3 op1 7", op1_3, 7);
        chk("m3 ovf cleared", {31'd0, ovf3}, 0);
        chk("m3 cnt 1", {28'd0, cnt3}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
